// File: rtl/bus_arbiter_pkg.sv
// Shared constants, state encoding and index helpers for the three-requester bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned NUM_REQ   = 3;
  localparam int unsigned REQ_FETCH = 0;
  localparam int unsigned REQ_DATA  = 1;
  localparam int unsigned REQ_AUX   = 2;

  typedef logic [1:0] req_idx_t;

  // Fixed encoding kept stable for legacy debug tooling.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // Next requester index in round-robin order, wrapping aux back to fetch.
  function automatic req_idx_t next_idx(input req_idx_t idx);
    return (idx >= req_idx_t'(NUM_REQ - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

  // Index of the set bit of a one-hot grant; zero when nothing is set.
  function automatic req_idx_t grant_to_idx(input logic [NUM_REQ-1:0] grant);
    req_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) idx = req_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_arb_select.sv
// Winner selection for bus_arbiter.
// BUS_ARB_ROUND_ROBIN_EN defined: round-robin starting after the last winner.
// Undefined: fixed priority data > fetch > aux, last winner unused.
module bus_arb_select
  import bus_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           last,
  output logic [NUM_REQ-1:0] grant
);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  req_idx_t idx0;
  req_idx_t idx1;
  req_idx_t idx2;

  // Search the requesters in rotated order beginning just after the last winner.
  always_comb begin
    idx0  = next_idx(last);
    idx1  = next_idx(idx0);
    idx2  = next_idx(idx1);
    grant = '0;
    if (req[idx0]) begin
      grant[idx0] = 1'b1;
    end else if (req[idx1]) begin
      grant[idx1] = 1'b1;
    end else if (req[idx2]) begin
      grant[idx2] = 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  // Static priority: data accesses first, then instruction fetch, then aux.
  always_comb begin
    grant = '0;
    if (req[REQ_DATA]) begin
      grant[REQ_DATA] = 1'b1;
    end else if (req[REQ_FETCH]) begin
      grant[REQ_FETCH] = 1'b1;
    end else if (req[REQ_AUX]) begin
      grant[REQ_AUX] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Three-requester single-slave bus arbiter with ack timeout.
// Arbitration policy selected by macro BUS_ARB_ROUND_ROBIN_EN (defined: round-robin,
// undefined: fixed priority). TIMEOUT must be at least 1.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_REQ-1:0]               i_req,
  input  logic [NUM_REQ-1:0]               i_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   i_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   i_wdata,
  input  logic [NUM_REQ-1:0][DATA_W/8-1:0] i_mask,
  output logic [NUM_REQ-1:0]               o_ack,
  output logic [NUM_REQ-1:0]               o_err,
  output logic [DATA_W-1:0]                o_rdata,
  output logic                             o_s_req,
  output logic                             o_s_we,
  output logic [ADDR_W-1:0]                o_s_addr,
  output logic [DATA_W-1:0]                o_s_wdata,
  output logic [DATA_W/8-1:0]              o_s_mask,
  input  logic                             i_s_ack,
  input  logic [DATA_W-1:0]                i_s_rdata,
  output logic [NUM_REQ-1:0]               o_grant,
  output logic                             o_busy
);

  // Count only reaches TIMEOUT-1 before the FSM leaves BUSY.
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  arb_state_e            state_q;
  arb_state_e            state_d;
  logic [NUM_REQ-1:0]    grant_q;
  logic [NUM_REQ-1:0]    sel_grant;
  req_idx_t              win_idx;
  req_idx_t              last_sel;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   mask_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [NUM_REQ-1:0]    ack_q;
  logic [NUM_REQ-1:0]    err_q;
  logic                  start;
  logic                  ack_hit;
  logic                  timeout_hit;

  assign start       = (state_q == ST_IDLE) && (|i_req);
  assign ack_hit     = (state_q == ST_BUSY) && i_s_ack;
  // A real ack in the final counted cycle takes precedence over the timeout.
  assign timeout_hit = (state_q == ST_BUSY) && !i_s_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign win_idx     = grant_to_idx(sel_grant);

  bus_arb_select u_select (
    .req   (i_req),
    .last  (last_sel),
    .grant (sel_grant)
  );

`ifdef BUS_ARB_ROUND_ROBIN_EN
  req_idx_t last_q;

  // Remember the most recent winner so the next search starts after it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_q <= req_idx_t'(REQ_AUX);
    end else if (start) begin
      last_q <= win_idx;
    end
  end

  assign last_sel = last_q;
`else
  assign last_sel = req_idx_t'(REQ_AUX);
`endif

  // Next-state logic for IDLE -> BUSY -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: if (ack_hit || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Owner tracking: set on grant, held through DONE so the ack can be steered, then cleared.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      grant_q <= '0;
    end else if (start) begin
      grant_q <= sel_grant;
    end else if (state_q == ST_DONE) begin
      grant_q <= '0;
    end
  end

  // Latch the winner's payload so the requester may change or drop it mid-transaction.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else if (start) begin
      we_q    <= i_we[win_idx];
      addr_q  <= i_addr[win_idx];
      wdata_q <= i_wdata[win_idx];
      mask_q  <= i_mask[win_idx];
    end
  end

  // Cycles spent in BUSY; held at zero elsewhere so each transaction starts fresh.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_BUSY) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Completion: one-cycle ack/err pulses in DONE, read data captured or zeroed on timeout.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      if (ack_hit) begin
        ack_q   <= grant_q;
        rdata_q <= i_s_rdata;
      end else if (timeout_hit) begin
        ack_q   <= grant_q;
        err_q   <= grant_q;
        rdata_q <= '0;
      end
    end
  end

  assign o_s_req   = (state_q == ST_BUSY);
  assign o_s_we    = (state_q == ST_BUSY) && we_q;
  assign o_s_addr  = addr_q;
  assign o_s_wdata = wdata_q;
  assign o_s_mask  = mask_q;
  assign o_busy    = (state_q == ST_BUSY);
  assign o_grant   = grant_q;
  assign o_ack     = ack_q;
  assign o_err     = err_q;
  assign o_rdata   = rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with a scoreboard of expected completions.
module tb_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  typedef struct {
    logic [2:0]    ack;
    logic [2:0]    err;
    logic [DW-1:0] rdata;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [2:0]            req;
  logic [2:0]            we;
  logic [2:0][AW-1:0]    addr;
  logic [2:0][DW-1:0]    wdata;
  logic [2:0][DW/8-1:0]  mask;
  logic [2:0]            ack;
  logic [2:0]            err;
  logic [DW-1:0]         rdata;
  logic                  s_req;
  logic                  s_we;
  logic [AW-1:0]         s_addr;
  logic [DW-1:0]         s_wdata;
  logic [DW/8-1:0]       s_mask;
  logic                  s_ack;
  logic [DW-1:0]         s_rdata;
  logic [2:0]            grant;
  logic                  busy;

  int   total = 0;
  int   bad   = 0;
  int   last_win;
  exp_t sb[$];

  always #5 clk = ~clk;

  bus_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_req     (req),
    .i_we      (we),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .i_mask    (mask),
    .o_ack     (ack),
    .o_err     (err),
    .o_rdata   (rdata),
    .o_s_req   (s_req),
    .o_s_we    (s_we),
    .o_s_addr  (s_addr),
    .o_s_wdata (s_wdata),
    .o_s_mask  (s_mask),
    .i_s_ack   (s_ack),
    .i_s_rdata (s_rdata),
    .o_grant   (grant),
    .o_busy    (busy)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration policy.
  function automatic logic [2:0] model_grant(input logic [2:0] r, input int last);
`ifdef BUS_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (r[i]) return 3'(1 << i);
    end
    return 3'b000;
`else
    if (r[1]) return 3'b010;
    if (r[0]) return 3'b001;
    if (r[2]) return 3'b100;
    return 3'b000;
`endif
  endfunction

  function automatic int oh_idx(input logic [2:0] g);
    if (g[2]) return 2;
    if (g[1]) return 1;
    return 0;
  endfunction

  // IDLE sampling edge: expect the model's winner and a live slave request.
  task automatic grant_step(input string tag, output int idx);
    logic [2:0] e;
    e = model_grant(req, last_win);
    tick();
    check({tag, "/grant"}, 64'(grant), 64'(e));
    check({tag, "/s_req"}, 64'(s_req), 64'd1);
    idx      = oh_idx(e);
    last_win = idx;
  endtask

  // Wait (bounded) for the ack pulse, compare against the scoreboard, then verify the pulse ends.
  task automatic finish_txn(input string tag, input int bound, input bit drop);
    int   n;
    exp_t e;
    n = 0;
    while (ack === 3'b000 && n < bound) begin
      tick();
      n++;
    end
    check({tag, "/ack_seen"}, 64'(|ack), 64'd1);
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s/sb: observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "/ack"}, 64'(ack), 64'(e.ack));
      check({tag, "/err"}, 64'(err), 64'(e.err));
      check({tag, "/rdata"}, 64'(rdata), 64'(e.rdata));
      if (drop) req = req & ~e.ack;
    end
    s_ack = 1'b0;
    tick();
    check({tag, "/ack_end"}, 64'(ack), 64'd0);
    check({tag, "/grant_clr"}, 64'(grant), 64'd0);
  endtask

  task automatic push_exp(input int idx, input logic [2:0] e_err, input logic [DW-1:0] d);
    exp_t e;
    e.ack   = 3'(1 << idx);
    e.err   = e_err;
    e.rdata = d;
    sb.push_back(e);
  endtask

  initial begin
    int w;
    int cnt;
    rst_n   = 1'b0;
    req     = '0;
    we      = '0;
    addr    = '0;
    wdata   = '0;
    mask    = '0;
    s_ack   = 1'b0;
    s_rdata = '0;
    last_win = 2;
    repeat (3) tick();

    // Reset state
    check("rst/s_req", 64'(s_req), 64'd0);
    check("rst/s_we", 64'(s_we), 64'd0);
    check("rst/ack", 64'(ack), 64'd0);
    check("rst/err", 64'(err), 64'd0);
    check("rst/grant", 64'(grant), 64'd0);
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/s_addr", 64'(s_addr), 64'd0);
    check("rst/s_wdata", 64'(s_wdata), 64'd0);
    check("rst/s_mask", 64'(s_mask), 64'd0);
    check("rst/rdata", 64'(rdata), 64'd0);
    rst_n = 1'b1;

    // Slave ack while idle is ignored
    s_ack   = 1'b1;
    s_rdata = 32'h5555_AAAA;
    tick();
    tick();
    check("idle_ack/ack", 64'(ack), 64'd0);
    check("idle_ack/busy", 64'(busy), 64'd0);
    check("idle_ack/rdata", 64'(rdata), 64'd0);
    s_ack = 1'b0;

    // Single data read, slave acks three cycles after grant
    req[1]  = 1'b1;
    we[1]   = 1'b0;
    addr[1] = 32'h0000_0100;
    grant_step("rd", w);
    check("rd/s_addr", 64'(s_addr), 64'h100);
    check("rd/s_we", 64'(s_we), 64'd0);
    check("rd/busy", 64'(busy), 64'd1);
    tick();
    tick();
    check("rd/s_req_hold", 64'(s_req), 64'd1);
    s_ack   = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    push_exp(1, 3'b000, 32'hDEAD_BEEF);
    finish_txn("rd", 1, 1'b1);

    // Best-case latency; fetch drops its request during BUSY and still completes
    req[0]  = 1'b1;
    addr[0] = 32'h0000_0200;
    grant_step("bc", w);
    check("bc/s_addr", 64'(s_addr), 64'h200);
    req[0]  = 1'b0;
    s_ack   = 1'b1;
    s_rdata = 32'h0BAD_F00D;
    push_exp(0, 3'b000, 32'h0BAD_F00D);
    finish_txn("bc", 1, 1'b0);

    // Contention between fetch and data in the same cycle
    req[0]  = 1'b1;
    req[1]  = 1'b1;
    addr[0] = 32'h0000_0300;
    addr[1] = 32'h0000_0400;
    grant_step("ct1", w);
    check("ct1/s_addr", 64'(s_addr), 64'(addr[w]));
    s_ack   = 1'b1;
    s_rdata = 32'h1111_0000;
    push_exp(w, 3'b000, 32'h1111_0000);
    finish_txn("ct1", 1, 1'b1);
    grant_step("ct2", w);
    check("ct2/s_addr", 64'(s_addr), 64'(addr[w]));
    s_ack   = 1'b1;
    s_rdata = 32'h2222_0000;
    push_exp(w, 3'b000, 32'h2222_0000);
    finish_txn("ct2", 1, 1'b1);

    // Masked aux write: payload held on the slave port until ack
    req[2]   = 1'b1;
    we[2]    = 1'b1;
    addr[2]  = 32'h0000_0010;
    wdata[2] = 32'h1234_5678;
    mask[2]  = 4'b0011;
    grant_step("wr", w);
    for (int k = 0; k < 3; k++) begin
      check("wr/s_we", 64'(s_we), 64'd1);
      check("wr/s_addr", 64'(s_addr), 64'h10);
      check("wr/s_wdata", 64'(s_wdata), 64'h1234_5678);
      check("wr/s_mask", 64'(s_mask), 64'h3);
      if (k < 2) tick();
    end
    s_ack   = 1'b1;
    s_rdata = 32'hCAFE_0000;
    push_exp(2, 3'b000, 32'hCAFE_0000);
    finish_txn("wr", 1, 1'b1);
    we[2] = 1'b0;

    // Timeout: slave never acks, request must stay up for exactly TO cycles
    req[1]  = 1'b1;
    addr[1] = 32'h0000_0500;
    grant_step("to", w);
    push_exp(w, 3'(1 << w), 32'h0);
    cnt = 0;
    for (int g = 0; g < 20; g++) begin
      if (ack !== 3'b000) break;
      if (s_req) cnt++;
      tick();
    end
    check("to/s_req_cycles", 64'(cnt), 64'(TO));
    check("to/s_req_drop", 64'(s_req), 64'd0);
    finish_txn("to", 0, 1'b1);

    // Ack on the final counted cycle beats the timeout
    req[1] = 1'b1;
    grant_step("to_ack", w);
    repeat (TO - 1) tick();
    check("to_ack/s_req", 64'(s_req), 64'd1);
    s_ack   = 1'b1;
    s_rdata = 32'h600D_600D;
    push_exp(w, 3'b000, 32'h600D_600D);
    finish_txn("to_ack", 1, 1'b1);

    // Reset two cycles after grant: slave request drops immediately, no ack
    req[0]  = 1'b1;
    addr[0] = 32'h0000_0600;
    grant_step("rstb", w);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rstb/s_req", 64'(s_req), 64'd0);
    check("rstb/busy", 64'(busy), 64'd0);
    check("rstb/grant", 64'(grant), 64'd0);
    tick();
    check("rstb/ack", 64'(ack), 64'd0);
    tick();
    rst_n    = 1'b1;
    last_win = 2;
    grant_step("rsta", w);
    check("rsta/s_addr", 64'(s_addr), 64'h600);
    s_ack   = 1'b1;
    s_rdata = 32'h7777_0001;
    push_exp(w, 3'b000, 32'h7777_0001);
    finish_txn("rsta", 1, 1'b1);

    // All three held continuously from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    last_win = 2;
    req      = 3'b111;
    for (int t = 0; t < 4; t++) begin
      grant_step("all", w);
      s_ack   = 1'b1;
      s_rdata = 32'hA000_0000 + 32'(t);
      push_exp(w, 3'b000, 32'hA000_0000 + 32'(t));
      finish_txn("all", 1, 1'b0);
    end
    req = '0;
    tick();
    check("end/busy", 64'(busy), 64'd0);
    check("end/sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
